// File: rtl/bgr_startup_ctrl.sv
// Start-up sequencer for the bandgap: issues porst kicks, qualifies the synced
// window-comparator flag, retries on timeout and reports ready/fault/dropout.
module bgr_startup_ctrl #(
  parameter int KICK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int OK_FILTER     = 8,
  parameter int MAX_RETRY     = 3,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bgr_ok,
  output logic          porst,
  output logic          bgr_ready,
  output logic          fault,
  output logic          dropout,
  output logic [RW-1:0] retry_cnt
);

  localparam int KW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FW = $clog2(OK_FILTER + 1);

  typedef enum logic [2:0] {IDLE, KICK, SETTLE, READY, FAULT} state_t;

  state_t        state, nxt;
  logic [1:0]    sync_q;
  logic          ok_s;
  logic [KW-1:0] kick_cnt;
  logic [TW-1:0] timer;
  logic [FW-1:0] ok_run, bad_run;
  logic          bump_retry, clr_retry, set_drop;

  assign ok_s = sync_q[1];

  always_comb begin
    nxt        = state;
    bump_retry = 1'b0;
    clr_retry  = 1'b0;
    set_drop   = 1'b0;
    if (!en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          nxt       = KICK;
          clr_retry = 1'b1;
        end
        KICK:
          if (kick_cnt == KW'(KICK_CYCLES - 1)) nxt = SETTLE;
        SETTLE:
          // a qualified flag beats a timeout landing on the same cycle
          if (ok_run == FW'(OK_FILTER)) begin
            nxt = READY;
          end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
              nxt        = KICK;
              bump_retry = 1'b1;
            end else begin
              nxt = FAULT;
            end
          end
        READY:
          if (bad_run == FW'(OK_FILTER)) begin
            nxt       = KICK;
            clr_retry = 1'b1;
            set_drop  = 1'b1;
          end
        FAULT:   nxt = FAULT;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync_q    <= '0;
      kick_cnt  <= '0;
      timer     <= '0;
      ok_run    <= '0;
      bad_run   <= '0;
      retry_cnt <= '0;
      porst     <= 1'b0;
      bgr_ready <= 1'b0;
      fault     <= 1'b0;
      dropout   <= 1'b0;
    end else begin
      state  <= nxt;
      sync_q <= {sync_q[0], bgr_ok};

      // timers only run while staying in their state, so they never wrap
      kick_cnt <= (state == KICK && nxt == KICK) ? kick_cnt + KW'(1) : '0;
      timer    <= (state == SETTLE && nxt == SETTLE) ? timer + TW'(1) : '0;

      if (state == KICK || !ok_s)          ok_run <= '0;
      else if (ok_run != FW'(OK_FILTER))   ok_run <= ok_run + FW'(1);

      if (ok_s)                            bad_run <= '0;
      else if (bad_run != FW'(OK_FILTER))  bad_run <= bad_run + FW'(1);

      if (nxt == IDLE || clr_retry) retry_cnt <= '0;
      else if (bump_retry)          retry_cnt <= retry_cnt + RW'(1);

      if (nxt == IDLE)   dropout <= 1'b0;
      else if (set_drop) dropout <= 1'b1;

      porst     <= (nxt == KICK);
      bgr_ready <= (nxt == READY);
      fault     <= (nxt == FAULT);
    end
  end

endmodule
